// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS pipeline: datapath/address widths, the 4-bit
// ALU operation codes produced by alu_control, and the forwarding-mux select
// encodings produced by the forwarding unit.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Widths
    localparam int DATA_W     = 32;
    localparam int ALU_CODE_W = 4;
    localparam int REG_ADDR_W = 5;
    localparam int SHAMT_W    = 5;
    localparam int FWD_W      = 2;

    // ALU operation codes
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI  = 4'b0011;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'b0100;
    localparam logic [ALU_CODE_W-1:0] ALU_ADDU = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_SUBU = 4'b0111;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'b1000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'b1001;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'b1010;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR  = 4'b1011;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'b1100;

    // Forwarding select encodings (11 behaves as FWD_IDEX)
    localparam logic [FWD_W-1:0] FWD_IDEX  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/etapa_ex_if.sv
// -----------------------------------------------------------------------------
// etapa_ex_if
// Bundles the ID/EX-side inputs and the EX/MEM-side outputs of the execute
// stage.
//   slave  : view of the execute stage (i_* in, o_* out)
//   master : view of whoever drives the stage (i_* out, o_* in)
// -----------------------------------------------------------------------------
interface etapa_ex_if
    import mips_pkg::*;
#(
    parameter int NB_DATA        = DATA_W,
    parameter int NB_ALU_CONTROL = ALU_CODE_W,
    parameter int NB_REG_ADDR    = REG_ADDR_W,
    parameter int NB_SHAMT       = SHAMT_W,
    parameter int NB_FWD         = FWD_W
);

    // ID/EX side
    logic                      i_valid;
    logic                      i_stall;
    logic                      i_flush;
    logic [NB_ALU_CONTROL-1:0] i_alu_code;
    logic [NB_DATA-1:0]        i_dato_a;
    logic [NB_DATA-1:0]        i_dato_b;
    logic [NB_DATA-1:0]        i_inmediato;
    logic                      i_alu_src;
    logic [NB_SHAMT-1:0]       i_shamt;
    logic                      i_shift_var;
    logic [NB_FWD-1:0]         i_fwd_a;
    logic [NB_FWD-1:0]         i_fwd_b;
    logic [NB_DATA-1:0]        i_dato_ex_mem;
    logic [NB_DATA-1:0]        i_dato_mem_wb;
    logic [NB_REG_ADDR-1:0]    i_reg_dst;
    logic                      i_regwrite;
    logic                      i_memread;
    logic                      i_memwrite;
    logic                      i_memtoreg;

    // EX/MEM side
    logic                      o_valid;
    logic [NB_DATA-1:0]        o_alu_result;
    logic [NB_DATA-1:0]        o_dato_store;
    logic [NB_REG_ADDR-1:0]    o_reg_dst;
    logic                      o_regwrite;
    logic                      o_memread;
    logic                      o_memwrite;
    logic                      o_memtoreg;
    logic                      o_zero;
    logic                      o_overflow;

    modport slave (
        input  i_valid, i_stall, i_flush, i_alu_code, i_dato_a, i_dato_b,
               i_inmediato, i_alu_src, i_shamt, i_shift_var, i_fwd_a, i_fwd_b,
               i_dato_ex_mem, i_dato_mem_wb, i_reg_dst, i_regwrite, i_memread,
               i_memwrite, i_memtoreg,
        output o_valid, o_alu_result, o_dato_store, o_reg_dst, o_regwrite,
               o_memread, o_memwrite, o_memtoreg, o_zero, o_overflow
    );

    modport master (
        output i_valid, i_stall, i_flush, i_alu_code, i_dato_a, i_dato_b,
               i_inmediato, i_alu_src, i_shamt, i_shift_var, i_fwd_a, i_fwd_b,
               i_dato_ex_mem, i_dato_mem_wb, i_reg_dst, i_regwrite, i_memread,
               i_memwrite, i_memtoreg,
        input  o_valid, o_alu_result, o_dato_store, o_reg_dst, o_regwrite,
               o_memread, o_memwrite, o_memtoreg, o_zero, o_overflow
    );

endinterface

// File: rtl/etapa_ex_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational MIPS ALU.
//   i_op_a, i_op_b : operands
//   i_sh           : shift amount
//   i_code         : operation code (mips_pkg ALU_*)
//   o_result       : result, wraps modulo 2^NB_DATA; unused codes give 0
//   o_zero         : o_result == 0
//   o_overflow     : signed overflow, only ever raised for ALU_ADD
// -----------------------------------------------------------------------------
module alu
    import mips_pkg::*;
#(
    parameter int NB_DATA        = DATA_W,
    parameter int NB_ALU_CONTROL = ALU_CODE_W,
    parameter int NB_SHAMT       = SHAMT_W
) (
    input  logic [NB_DATA-1:0]        i_op_a,
    input  logic [NB_DATA-1:0]        i_op_b,
    input  logic [NB_SHAMT-1:0]       i_sh,
    input  logic [NB_ALU_CONTROL-1:0] i_code,
    output logic [NB_DATA-1:0]        o_result,
    output logic                      o_zero,
    output logic                      o_overflow
);

    logic [NB_DATA-1:0] w_sum;
    logic               w_lt;

    assign w_sum = i_op_a + i_op_b;
    assign w_lt  = $signed(i_op_a) < $signed(i_op_b);

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_code)
            ALU_SLL:  o_result = i_op_b << i_sh;
            ALU_SRL:  o_result = i_op_b >> i_sh;
            ALU_SRA:  o_result = $signed(i_op_b) >>> i_sh;
            ALU_LUI:  o_result = {i_op_b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
            ALU_ADD: begin
                o_result   = w_sum;
                // Same-sign operands producing a different-sign sum
                o_overflow = (i_op_a[NB_DATA-1] == i_op_b[NB_DATA-1]) &&
                             (w_sum[NB_DATA-1] != i_op_a[NB_DATA-1]);
            end
            ALU_ADDU: o_result = w_sum;
            ALU_SUBU: o_result = i_op_a - i_op_b;
            ALU_AND:  o_result = i_op_a & i_op_b;
            ALU_OR:   o_result = i_op_a | i_op_b;
            ALU_XOR:  o_result = i_op_a ^ i_op_b;
            ALU_NOR:  o_result = ~(i_op_a | i_op_b);
            ALU_SLT:  o_result = {{(NB_DATA-1){1'b0}}, w_lt};
            default:  o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/etapa_ex.sv
// -----------------------------------------------------------------------------
// etapa_ex
// Execute stage of the 5-stage MIPS pipeline. Selects operands through the
// forwarding and ALU-source muxes, runs the ALU and captures the result plus
// pass-through control into the EX/MEM register.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : etapa_ex_if.slave, ID/EX inputs (i_*) and EX/MEM outputs (o_*)
// Register update priority: reset > flush > stall > load. Latency is one
// cycle; every output comes straight from a register.
// -----------------------------------------------------------------------------
module etapa_ex
    import mips_pkg::*;
#(
    parameter int NB_DATA        = DATA_W,
    parameter int NB_ALU_CONTROL = ALU_CODE_W,
    parameter int NB_REG_ADDR    = REG_ADDR_W,
    parameter int NB_SHAMT       = SHAMT_W,
    parameter int NB_FWD         = FWD_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    etapa_ex_if.slave  bus
);

    logic [NB_DATA-1:0]  w_op_a;
    logic [NB_DATA-1:0]  w_fwd_b;
    logic [NB_DATA-1:0]  w_op_b;
    logic [NB_SHAMT-1:0] w_sh;
    logic [NB_DATA-1:0]  w_result;
    logic                w_zero;
    logic                w_overflow;

    logic                   r_valid;
    logic [NB_DATA-1:0]     r_alu_result;
    logic [NB_DATA-1:0]     r_dato_store;
    logic [NB_REG_ADDR-1:0] r_reg_dst;
    logic                   r_regwrite;
    logic                   r_memread;
    logic                   r_memwrite;
    logic                   r_memtoreg;
    logic                   r_zero;
    logic                   r_overflow;

    // Forwarding muxes; select 11 falls through to the ID/EX value
    always_comb begin
        case (bus.i_fwd_a)
            FWD_MEMWB: w_op_a = bus.i_dato_mem_wb;
            FWD_EXMEM: w_op_a = bus.i_dato_ex_mem;
            default:   w_op_a = bus.i_dato_a;
        endcase
    end

    always_comb begin
        case (bus.i_fwd_b)
            FWD_MEMWB: w_fwd_b = bus.i_dato_mem_wb;
            FWD_EXMEM: w_fwd_b = bus.i_dato_ex_mem;
            default:   w_fwd_b = bus.i_dato_b;
        endcase
    end

    assign w_op_b = bus.i_alu_src ? bus.i_inmediato : w_fwd_b;
    assign w_sh   = bus.i_shift_var ? w_op_a[NB_SHAMT-1:0] : bus.i_shamt;

    alu #(
        .NB_DATA        (NB_DATA),
        .NB_ALU_CONTROL (NB_ALU_CONTROL),
        .NB_SHAMT       (NB_SHAMT)
    ) u_alu (
        .i_op_a     (w_op_a),
        .i_op_b     (w_op_b),
        .i_sh       (w_sh),
        .i_code     (bus.i_alu_code),
        .o_result   (w_result),
        .o_zero     (w_zero),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_flush) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_dato_store <= '0;
            r_reg_dst    <= '0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (!bus.i_stall) begin
            r_valid      <= bus.i_valid;
            r_alu_result <= w_result;
            r_dato_store <= w_fwd_b;
            r_reg_dst    <= bus.i_reg_dst;
            // An overflowing add must not commit its wrapped sum
            r_regwrite   <= bus.i_valid & bus.i_regwrite & ~w_overflow;
            r_memread    <= bus.i_valid & bus.i_memread;
            r_memwrite   <= bus.i_valid & bus.i_memwrite;
            r_memtoreg   <= bus.i_valid & bus.i_memtoreg;
            r_zero       <= w_zero;
            // A bubble cannot raise an exception
            r_overflow   <= bus.i_valid & w_overflow;
        end
    end

    assign bus.o_valid      = r_valid;
    assign bus.o_alu_result = r_alu_result;
    assign bus.o_dato_store = r_dato_store;
    assign bus.o_reg_dst    = r_reg_dst;
    assign bus.o_regwrite   = r_regwrite;
    assign bus.o_memread    = r_memread;
    assign bus.o_memwrite   = r_memwrite;
    assign bus.o_memtoreg   = r_memtoreg;
    assign bus.o_zero       = r_zero;
    assign bus.o_overflow   = r_overflow;

endmodule

// File: tb/tb_etapa_ex.sv
// -----------------------------------------------------------------------------
// tb_etapa_ex
// Self-checking bench for etapa_ex: directed cases plus randomized traffic
// compared against a behavioural model of the EX/MEM register contents.
// -----------------------------------------------------------------------------
module tb_etapa_ex;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    etapa_ex_if bus ();

    etapa_ex dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] res;
        logic [31:0] store;
        logic [4:0]  dst;
        logic        rw, mr, mw, mt, zero, ovf;
    } ex_mem_t;

    ex_mem_t exp_q;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned fwd(input logic [1:0] sel, input int unsigned own,
                                        input int unsigned exm, input int unsigned mwb);
        if (sel == 2'b10) return exm;
        if (sel == 2'b01) return mwb;
        return own;
    endfunction

    // What EX/MEM should hold after a plain load with the current inputs
    function automatic ex_mem_t model_load();
        ex_mem_t     m;
        int unsigned a, fb, b, sh, r;
        longint      s;
        logic        ov;
        a  = fwd(bus.i_fwd_a, bus.i_dato_a, bus.i_dato_ex_mem, bus.i_dato_mem_wb);
        fb = fwd(bus.i_fwd_b, bus.i_dato_b, bus.i_dato_ex_mem, bus.i_dato_mem_wb);
        b  = bus.i_alu_src ? bus.i_inmediato : fb;
        sh = bus.i_shift_var ? (a % 32) : bus.i_shamt;
        ov = 1'b0;
        s  = 0;
        case (bus.i_alu_code)
            4'd0:  r = b << sh;
            4'd1:  r = b >> sh;
            4'd2:  r = int'(b) >>> sh;
            4'd3:  r = (b % 65536) * 65536;
            4'd4: begin
                s  = longint'(int'(a)) + longint'(int'(b));
                r  = s[31:0];
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6:  r = a + b;
            4'd7:  r = a - b;
            4'd8:  r = a & b;
            4'd9:  r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~(a | b);
            4'd12: r = (int'(a) < int'(b)) ? 1 : 0;
            default: r = 0;
        endcase
        m.valid = bus.i_valid;
        m.res   = r;
        m.store = fb;
        m.dst   = bus.i_reg_dst;
        m.rw    = bus.i_valid && bus.i_regwrite && !ov;
        m.mr    = bus.i_valid && bus.i_memread;
        m.mw    = bus.i_valid && bus.i_memwrite;
        m.mt    = bus.i_valid && bus.i_memtoreg;
        m.zero  = (r == 0);
        m.ovf   = bus.i_valid && ov;
        return m;
    endfunction

    function automatic ex_mem_t empty_state();
        ex_mem_t m;
        m.valid = 0; m.res = 0; m.store = 0; m.dst = 0;
        m.rw = 0; m.mr = 0; m.mw = 0; m.mt = 0; m.zero = 0; m.ovf = 0;
        return m;
    endfunction

    // One clock: predict, advance, then compare every output
    task automatic step(input string tag);
        ex_mem_t nxt;
        if (!rst_n || bus.i_flush) nxt = empty_state();
        else if (bus.i_stall)      nxt = exp_q;
        else                       nxt = model_load();
        @(posedge clk);
        exp_q = nxt;
        #1;
        chk({tag, ".valid"}, bus.o_valid,      exp_q.valid);
        chk({tag, ".res"},   bus.o_alu_result, exp_q.res);
        chk({tag, ".store"}, bus.o_dato_store, exp_q.store);
        chk({tag, ".dst"},   bus.o_reg_dst,    exp_q.dst);
        chk({tag, ".rw"},    bus.o_regwrite,   exp_q.rw);
        chk({tag, ".mr"},    bus.o_memread,    exp_q.mr);
        chk({tag, ".mw"},    bus.o_memwrite,   exp_q.mw);
        chk({tag, ".mt"},    bus.o_memtoreg,   exp_q.mt);
        chk({tag, ".zero"},  bus.o_zero,       exp_q.zero);
        chk({tag, ".ovf"},   bus.o_overflow,   exp_q.ovf);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        bus.i_valid       = ($urandom_range(0, 7) != 0);
        bus.i_alu_code    = 4'($urandom_range(0, 15));
        bus.i_dato_a      = rand_word();
        bus.i_dato_b      = rand_word();
        bus.i_inmediato   = rand_word();
        bus.i_alu_src     = 1'($urandom);
        bus.i_shamt       = 5'($urandom);
        bus.i_shift_var   = 1'($urandom);
        bus.i_fwd_a       = 2'($urandom);
        bus.i_fwd_b       = 2'($urandom);
        bus.i_dato_ex_mem = rand_word();
        bus.i_dato_mem_wb = rand_word();
        bus.i_reg_dst     = 5'($urandom);
        bus.i_regwrite    = 1'($urandom);
        bus.i_memread     = 1'($urandom);
        bus.i_memwrite    = 1'($urandom);
        bus.i_memtoreg    = 1'($urandom);
    endtask

    task automatic set_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.i_valid = 1; bus.i_stall = 0; bus.i_flush = 0;
        bus.i_alu_code = code; bus.i_dato_a = a; bus.i_dato_b = b;
        bus.i_inmediato = 0; bus.i_alu_src = 0; bus.i_shamt = 0; bus.i_shift_var = 0;
        bus.i_fwd_a = FWD_IDEX; bus.i_fwd_b = FWD_IDEX;
        bus.i_dato_ex_mem = 0; bus.i_dato_mem_wb = 0; bus.i_reg_dst = 5'd9;
        bus.i_regwrite = 1; bus.i_memread = 0; bus.i_memwrite = 0; bus.i_memtoreg = 0;
    endtask

    initial begin
        exp_q = empty_state();
        rst_n = 0;
        rand_inputs();
        bus.i_stall = 1'($urandom);
        bus.i_flush = 0;
        step("rst0");
        rand_inputs();
        step("rst1");
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_res", bus.o_alu_result, 0);
        rst_n = 1;

        set_op(ALU_ADDU, 32'hFFFF_FFFF, 32'h1);
        step("addu_wrap");
        chk("addu_wrap_res", bus.o_alu_result, 32'h0);
        chk("addu_wrap_zero", bus.o_zero, 1);
        chk("addu_wrap_ovf", bus.o_overflow, 0);

        set_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        step("add_ovf");
        chk("add_ovf_res", bus.o_alu_result, 32'h8000_0000);
        chk("add_ovf_flag", bus.o_overflow, 1);
        chk("add_ovf_rw", bus.o_regwrite, 0);

        set_op(ALU_SRA, 32'h0, 32'h8000_0000);
        bus.i_shamt = 5'd4;
        step("sra");
        chk("sra_res", bus.o_alu_result, 32'hF800_0000);

        set_op(ALU_SLL, 32'd33, 32'h1);
        bus.i_shift_var = 1; bus.i_shamt = 5'd7;
        step("sllv");
        chk("sllv_res", bus.o_alu_result, 32'h2);

        set_op(ALU_LUI, 32'h0, 32'h0);
        bus.i_alu_src = 1; bus.i_inmediato = 32'h1234;
        step("lui");
        chk("lui_res", bus.o_alu_result, 32'h1234_0000);

        set_op(ALU_SLT, 32'd100, 32'hDEAD_BEEF);
        bus.i_fwd_a = FWD_EXMEM; bus.i_dato_ex_mem = -32'sd5;
        bus.i_fwd_b = FWD_MEMWB; bus.i_dato_mem_wb = 32'd3;
        bus.i_alu_src = 1; bus.i_inmediato = 32'd3;
        step("slt_fwd");
        chk("slt_res", bus.o_alu_result, 32'd1);
        chk("slt_store", bus.o_dato_store, 32'd3);

        set_op(ALU_ADDU, 32'd3, 32'd4);
        bus.i_memwrite = 1;
        step("addu7");
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.i_stall = 1; bus.i_flush = 0;
            step("stall");
            chk("stall_res", bus.o_alu_result, 32'd7);
        end
        bus.i_stall = 1; bus.i_flush = 1;
        step("flush_stall");
        chk("flush_valid", bus.o_valid, 0);
        chk("flush_rw", bus.o_regwrite, 0);
        chk("flush_mw", bus.o_memwrite, 0);

        set_op(ALU_OR, 32'h5, 32'h6);
        bus.i_valid = 0; bus.i_memwrite = 1;
        step("invalid");
        chk("invalid_rw", bus.o_regwrite, 0);
        chk("invalid_mw", bus.o_memwrite, 0);

        set_op(4'b1110, 32'h1234, 32'h5678);
        step("unused");
        chk("unused_res", bus.o_alu_result, 32'h0);
        chk("unused_zero", bus.o_zero, 1);

        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            bus.i_stall = ($urandom_range(0, 7) == 0);
            bus.i_flush = ($urandom_range(0, 15) == 0);
            rst_n       = ($urandom_range(0, 63) != 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/etapa_ex.md
Name: etapa_ex

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of alu_control.
- Consumes the 4-bit ALU code with the ID/EX operands and selects operands through forwarding and ALU-source muxes.
- Computes the ALU result and captures it, with pass-through control bits, in the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
NB_DATA, 32, datapath width
NB_ALU_CONTROL, 4, ALU code width
NB_REG_ADDR, 5, register address width
NB_SHAMT, 5, shift amount width
NB_FWD, 2, forwarding select width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_valid  in  1  ID/EX holds a real instruction
i_stall  in  1  hold EX/MEM contents
i_flush  in  1  load a bubble into EX/MEM
i_alu_code  in  NB_ALU_CONTROL  operation code from alu_control
i_dato_a  in  NB_DATA  rs value from ID/EX
i_dato_b  in  NB_DATA  rt value from ID/EX
i_inmediato  in  NB_DATA  sign-extended immediate
i_alu_src  in  1  1: operand B = immediate
i_shamt  in  NB_SHAMT  instruction shamt field
i_shift_var  in  1  1: shift amount = operand A[4:0] (sllv/srlv/srav)
i_fwd_a  in  NB_FWD  00 ID/EX, 01 MEM/WB, 10 EX/MEM
i_fwd_b  in  NB_FWD  same encoding, applied to rt
i_dato_ex_mem  in  NB_DATA  forwarded EX/MEM result
i_dato_mem_wb  in  NB_DATA  forwarded MEM/WB result
i_reg_dst  in  NB_REG_ADDR  destination register
i_regwrite, i_memread, i_memwrite, i_memtoreg  in  1 each  control bits
o_valid  out  1  EX/MEM holds a real instruction
o_alu_result  out  NB_DATA  registered ALU result
o_dato_store  out  NB_DATA  registered forwarded rt, used by sw
o_reg_dst  out  NB_REG_ADDR  registered destination register
o_regwrite, o_memread, o_memwrite, o_memtoreg  out  1 each  registered control bits
o_zero  out  1  registered (result == 0)
o_overflow  out  1  registered signed-add overflow

Behaviour:
- Reset: one clock; i_rst_n is synchronous and active-low.
- Reset values: all outputs 0, sampled on the i_clk rising edge while i_rst_n=0.
- Operand A is the forwarding mux output for rs. Forwarding select 11 is treated as 00.
- Forwarded rt (fwd_b) is the forwarding mux output for rt.
- Operand B = i_alu_src ? i_inmediato : fwd_b.
- Shift amount = i_shift_var ? opA[4:0] : i_shamt.
- Codes:
  - 0000 sll: B << sh
  - 0001 srl: B >> sh, logical
  - 0010 sra: B >>> sh, arithmetic
  - 0011 lui: {B[15:0], 16'h0}
  - 0100 add: A+B, signed, overflow detected
  - 0110 addu: A+B
  - 0111 subu: A-B
  - 1000 and
  - 1001 or
  - 1010 xor
  - 1011 nor
  - 1100 slt: signed compare, result 1 or 0
  - Unused codes (0101, 1101-1111): result 0.
- Arithmetic wraps modulo 2^32. Overflow is flagged only for code 0100, when the operand signs match and the result sign differs.
- On overflow: o_overflow=1, o_regwrite forced to 0, o_alu_result still carries the wrapped sum.
- o_zero is computed from the full 32-bit result.
- Register update priority: reset > flush > stall > load.
  - Flush: o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg, o_overflow all 0. Data fields are don't-care; they are driven to 0.
  - Stall: all outputs hold.
  - Load: capture all computed values.
- Flush and stall asserted together: flush wins.
- i_valid=0 on load: o_valid=0, and all write/mem control bits are gated to 0.
- Latency: exactly 1 cycle from inputs to EX/MEM outputs. No combinational path from inputs to outputs.

Decomposition:
- Package mips_pkg:
  - ALU code localparams (ALU_SLL..ALU_SLT), shared with alu_control.
  - Forwarding select encodings (FWD_IDEX, FWD_MEMWB, FWD_EXMEM).
  - Data and address width constants.
- Sub-module alu: purely combinational. Takes (opA, opB, sh, code) and produces (result, zero, overflow).
- etapa_ex contains the muxes and the EX/MEM register.

Test Plan:
- Reset: i_rst_n=0 for 2 cycles with random inputs -> all outputs 0. Release -> first load occurs on the next edge.
- Arithmetic: code 0110, A=0xFFFFFFFF, B=1 -> result 0, o_zero=1, o_overflow=0. Code 0100, A=0x7FFFFFFF, B=1 -> result 0x80000000, o_overflow=1, o_regwrite=0.
- Shifts/lui: code 0010, B=0x80000000, i_shamt=4 -> 0xF8000000. Code 0000, i_shift_var=1, A=33, B=1 -> 0x2 (A[4:0]=1). Code 0011, imm=0x1234 -> 0x12340000.
- Forwarding/slt: i_fwd_a=10, i_dato_ex_mem=-5; i_fwd_b=01, i_dato_mem_wb=3; code 1100 -> result 1. Also check o_dato_store=3 with i_alu_src=1.
- Stall/flush: load an addu producing 7, then assert i_stall for 3 cycles with new inputs -> outputs stay 7. Assert i_flush with i_stall -> o_valid=0, o_regwrite=0, o_memwrite=0.
- Invalid/unused: i_valid=0 with i_regwrite=1, i_memwrite=1 -> both outputs 0. Code 1110 -> o_alu_result 0, o_zero=1.
